// File: rtl/cpu_axi_arbiter.sv
// cpu_axi_arbiter
//   Merges the core's inst and data SRAM-like ports onto one AXI master.
//   Only one single-beat transaction is in flight at any time.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   inst_*_i / inst_*_o       inst port: req/wr/size/addr/wdata in; rdata, addr_ok, data_ok out
//   data_*_i / data_*_o       data port, same set as inst
//   ar*/r*/aw*/w*/b*          AXI master channels (AXI3-style, with wid)
// Parameters:
//   ARB_MODE  0 = data always wins a tie, 1 = last winner loses a tie
//   INST_ID, DATA_ID          AXI IDs stamped on each owner's transactions
module cpu_axi_arbiter #(
  parameter int unsigned ARB_MODE = 0,
  parameter logic [3:0]  INST_ID  = 4'd0,
  parameter logic [3:0]  DATA_ID  = 4'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // inst port
  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_wdata_i,
  output logic [31:0] inst_rdata_o,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  // data port
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  // AXI read address
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic [1:0]  arlock_o,
  output logic [3:0]  arcache_o,
  output logic [2:0]  arprot_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  // AXI read data
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  // AXI write address
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic [1:0]  awlock_o,
  output logic [3:0]  awcache_o,
  output logic [2:0]  awprot_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  // AXI write data
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  // AXI write response
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WRITE, S_WRESP} state_e;

  state_e      state_q, state_d;
  logic        owner_q;        // 0 = inst, 1 = data
  logic        last_data_q;    // last grant went to data
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        aw_done_q, w_done_q;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        inst_dok_q, data_dok_q;

  logic        grant_v, grant_data;
  logic        win_wr;
  logic [1:0]  win_size;
  logic [31:0] win_addr, win_wdata;
  logic        aw_fire, w_fire, done;
  logic [1:0]  eff_size;

  // Only one transaction is ever outstanding, so response IDs/status carry no information.
  logic unused_ok;
  assign unused_ok = ^{rid_i, rresp_i, rlast_i, bid_i, bresp_i};

  // Arbitration
  always_comb begin
    grant_data = data_req_i;
    if (inst_req_i && data_req_i)
      grant_data = (ARB_MODE == 0) ? 1'b1 : !last_data_q;
  end

  // Grants are suppressed while reset is asserted; the request would be lost anyway.
  assign grant_v   = (state_q == S_IDLE) && (inst_req_i || data_req_i) && !rst_i;
  assign win_wr    = grant_data ? data_wr_i    : inst_wr_i;
  assign win_size  = grant_data ? data_size_i  : inst_size_i;
  assign win_addr  = grant_data ? data_addr_i  : inst_addr_i;
  assign win_wdata = grant_data ? data_wdata_i : inst_wdata_i;

  assign aw_fire = awvalid_o && awready_i;
  assign w_fire  = wvalid_o && wready_i;
  assign done    = ((state_q == S_RDATA) && rvalid_i) || ((state_q == S_WRESP) && bvalid_i);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_v) state_d = win_wr ? S_WRITE : S_RADDR;
      S_RADDR: if (arready_i) state_d = S_RDATA;
      S_RDATA: if (rvalid_i) state_d = S_IDLE;
      // AW and W may complete in either order or together.
      S_WRITE: if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = S_WRESP;
      S_WRESP: if (bvalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    inst_addr_ok_o = grant_v && !grant_data;
    data_addr_ok_o = grant_v && grant_data;
    arvalid_o      = (state_q == S_RADDR);
    rready_o       = (state_q == S_RDATA);
    awvalid_o      = (state_q == S_WRITE) && !aw_done_q;
    wvalid_o       = (state_q == S_WRITE) && !w_done_q;
    bready_o       = (state_q == S_WRESP);
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q      <= 1'b0;
      last_data_q  <= 1'b1;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_dok_q   <= 1'b0;
      data_dok_q   <= 1'b0;
    end else begin
      if (grant_v) begin
        owner_q     <= grant_data;
        last_data_q <= grant_data;
        wr_q        <= win_wr;
        size_q      <= win_size;
        addr_q      <= win_addr;
        wdata_q     <= win_wdata;
      end
      if (state_q == S_WRITE) begin
        aw_done_q <= aw_done_q || aw_fire;
        w_done_q  <= w_done_q || w_fire;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if ((state_q == S_RDATA) && rvalid_i) begin
        if (owner_q) data_rdata_q <= rdata_i;
        else         inst_rdata_q <= rdata_i;
      end
      inst_dok_q <= done && !owner_q;
      data_dok_q <= done && owner_q;
    end
  end

  assign inst_rdata_o   = inst_rdata_q;
  assign data_rdata_o   = data_rdata_q;
  assign inst_data_ok_o = inst_dok_q;
  assign data_data_ok_o = data_dok_q;

  // Size 3 is treated as a word access.
  assign eff_size = (size_q == 2'd3) ? 2'd2 : size_q;

  always_comb begin
    wstrb_o = 4'b1111;
    case (eff_size)
      2'd0:    wstrb_o = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb_o = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb_o = 4'b1111;
    endcase
  end

  // Fixed and latched AXI fields
  assign arid_o    = owner_q ? DATA_ID : INST_ID;
  assign araddr_o  = addr_q;
  assign arlen_o   = 4'd0;
  assign arsize_o  = {1'b0, eff_size};
  assign arburst_o = 2'b01;
  assign arlock_o  = 2'd0;
  assign arcache_o = 4'd0;
  assign arprot_o  = 3'd0;

  assign awid_o    = arid_o;
  assign awaddr_o  = addr_q;
  assign awlen_o   = 4'd0;
  assign awsize_o  = {1'b0, eff_size};
  assign awburst_o = 2'b01;
  assign awlock_o  = 2'd0;
  assign awcache_o = 4'd0;
  assign awprot_o  = 3'd0;

  assign wid_o     = awid_o;
  assign wdata_o   = wdata_q;
  assign wlast_o   = 1'b1;

  // wr_q is kept for debug visibility of the latched request.
  logic unused_wr;
  assign unused_wr = wr_q;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Bench for cpu_axi_arbiter: one instance per ARB_MODE, each with its own
// core-side and slave-side stimulus. Expected cycle timing, AXI fields and
// arbitration order come from a small model kept here.
module tb_cpu_axi_arbiter;

  logic clk;
  logic rst [2];
  // [mode][port], port 0 = inst, 1 = data
  logic        req   [2][2];
  logic        wr    [2][2];
  logic [1:0]  size  [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [31:0] rdata [2][2];
  logic        aok   [2][2];
  logic        dok   [2][2];

  logic [3:0]  arid [2];    logic [31:0] araddr [2]; logic [3:0] arlen [2];
  logic [2:0]  arsize [2];  logic [1:0]  arburst [2]; logic [1:0] arlock [2];
  logic [3:0]  arcache [2]; logic [2:0]  arprot [2];  logic arvalid [2], arready [2];
  logic [3:0]  rid [2];     logic [31:0] rdata_in [2]; logic [1:0] rresp [2];
  logic        rlast [2], rvalid [2], rready [2];
  logic [3:0]  awid [2];    logic [31:0] awaddr [2]; logic [3:0] awlen [2];
  logic [2:0]  awsize [2];  logic [1:0]  awburst [2]; logic [1:0] awlock [2];
  logic [3:0]  awcache [2]; logic [2:0]  awprot [2];  logic awvalid [2], awready [2];
  logic [3:0]  wid [2];     logic [31:0] axi_wdata [2]; logic [3:0] wstrb [2];
  logic        wlast [2], wvalid [2], wready [2];
  logic [3:0]  bid [2];     logic [1:0]  bresp [2];   logic bvalid [2], bready [2];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] model_rdata [2][2];
  int          model_last  [2];   // last granted port

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_axi_arbiter #(.ARB_MODE(g), .INST_ID(4'd0), .DATA_ID(4'd1)) u_dut (
      .clk_i(clk), .rst_i(rst[g]),
      .inst_req_i(req[g][0]), .inst_wr_i(wr[g][0]), .inst_size_i(size[g][0]),
      .inst_addr_i(addr[g][0]), .inst_wdata_i(wdata[g][0]), .inst_rdata_o(rdata[g][0]),
      .inst_addr_ok_o(aok[g][0]), .inst_data_ok_o(dok[g][0]),
      .data_req_i(req[g][1]), .data_wr_i(wr[g][1]), .data_size_i(size[g][1]),
      .data_addr_i(addr[g][1]), .data_wdata_i(wdata[g][1]), .data_rdata_o(rdata[g][1]),
      .data_addr_ok_o(aok[g][1]), .data_data_ok_o(dok[g][1]),
      .arid_o(arid[g]), .araddr_o(araddr[g]), .arlen_o(arlen[g]), .arsize_o(arsize[g]),
      .arburst_o(arburst[g]), .arlock_o(arlock[g]), .arcache_o(arcache[g]), .arprot_o(arprot[g]),
      .arvalid_o(arvalid[g]), .arready_i(arready[g]),
      .rid_i(rid[g]), .rdata_i(rdata_in[g]), .rresp_i(rresp[g]), .rlast_i(rlast[g]),
      .rvalid_i(rvalid[g]), .rready_o(rready[g]),
      .awid_o(awid[g]), .awaddr_o(awaddr[g]), .awlen_o(awlen[g]), .awsize_o(awsize[g]),
      .awburst_o(awburst[g]), .awlock_o(awlock[g]), .awcache_o(awcache[g]), .awprot_o(awprot[g]),
      .awvalid_o(awvalid[g]), .awready_i(awready[g]),
      .wid_o(wid[g]), .wdata_o(axi_wdata[g]), .wstrb_o(wstrb[g]), .wlast_o(wlast[g]),
      .wvalid_o(wvalid[g]), .wready_i(wready[g]),
      .bid_i(bid[g]), .bresp_i(bresp[g]), .bvalid_i(bvalid[g]), .bready_o(bready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slave(input int m);
    arready[m] = 1'b0; rvalid[m] = 1'b0; awready[m] = 1'b0; wready[m] = 1'b0; bvalid[m] = 1'b0;
    rdata_in[m] = $urandom;
    rid[m] = 4'($urandom); bid[m] = 4'($urandom); rresp[m] = 2'($urandom); bresp[m] = 2'($urandom);
    rlast[m] = 1'($urandom);
  endtask

  task automatic model_reset(input int m);
    model_last[m] = 1;
    model_rdata[m][0] = 32'd0;
    model_rdata[m][1] = 32'd0;
  endtask

  task automatic do_reset(input int m);
    rst[m] = 1'b1;
    step; step;
    rst[m] = 1'b0;
    model_reset(m);
  endtask

  // One request on port p of instance m, slave delays in cycles.
  task automatic run_txn(input int m, input int p, input bit w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int dar, input int dr, input int daw, input int dw, input int db);
    int ar_c, r_s, r_c, aw_c, w_c, b_s, b_c, ok_c, nb, off;
    logic [2:0] esz;
    logic [3:0] estrb, eid;
    logic [8:0] exp_v, obs_v;
    esz   = (sz == 2'd3) ? 3'd2 : {1'b0, sz};
    nb    = 1 << esz;
    off   = int'(a[1:0]) / nb * nb;
    estrb = 4'(((1 << nb) - 1) << off);
    eid   = (p == 1) ? 4'd1 : 4'd0;
    ar_c = 1 + dar; r_s = ar_c + 1; r_c = r_s + dr;
    aw_c = 1 + daw; w_c = 1 + dw;
    b_s  = ((aw_c > w_c) ? aw_c : w_c) + 1; b_c = b_s + db;
    ok_c = w ? b_c + 1 : r_c + 1;

    req[m][p] = 1'b1; wr[m][p] = w; size[m][p] = sz; addr[m][p] = a; wdata[m][p] = wd;
    @(negedge clk);
    checks++;
    if ({aok[m][1], aok[m][0]} !== 2'(1 << p)) begin
      errors++;
      $display("FAIL addr_ok m%0d got %b exp %b", m, {aok[m][1], aok[m][0]}, 2'(1 << p));
    end
    model_last[m] = p;
    step;
    // Request fields change after acceptance; the DUT must use the latched copy.
    req[m][p] = 1'b0; addr[m][p] = $urandom; wdata[m][p] = $urandom; wr[m][p] = 1'($urandom);
    for (int c = 1; c <= ok_c; c++) begin
      clear_slave(m);
      arready[m] = !w && (c == ar_c);
      rvalid[m]  = !w && (c == r_c);
      if (c == r_c) rdata_in[m] = rd;
      awready[m] = w && (c == aw_c);
      wready[m]  = w && (c == w_c);
      bvalid[m]  = w && (c == b_c);
      @(negedge clk);
      exp_v = {!w && c <= ar_c, !w && c >= r_s && c <= r_c, w && c <= aw_c, w && c <= w_c,
               w && c >= b_s && c <= b_c, c == ok_c && p == 1, c == ok_c && p == 0, 2'b00};
      obs_v = {arvalid[m], rready[m], awvalid[m], wvalid[m], bready[m],
               dok[m][1], dok[m][0], aok[m][1], aok[m][0]};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL handshake m%0d cyc %0d got %b exp %b", m, c, obs_v, exp_v);
      end
      if (c == 1) begin
        checks++;
        if (!w && {arid[m], araddr[m], arsize[m], arlen[m], arburst[m], arlock[m], arcache[m], arprot[m]}
                  !== {eid, a, esz, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0}) begin
          errors++;
          $display("FAIL ar_fields m%0d got id %h addr %h size %0d len %0d burst %b exp id %h addr %h size %0d",
                   m, arid[m], araddr[m], arsize[m], arlen[m], arburst[m], eid, a, esz);
        end
        if (w && {awid[m], awaddr[m], awsize[m], awlen[m], awburst[m], wid[m], axi_wdata[m], wstrb[m], wlast[m]}
                 !== {eid, a, esz, 4'd0, 2'b01, eid, wd, estrb, 1'b1}) begin
          errors++;
          $display("FAIL aw_fields m%0d got id %h addr %h size %0d wid %h wdata %h strb %b wlast %b exp id %h addr %h size %0d wdata %h strb %b",
                   m, awid[m], awaddr[m], awsize[m], wid[m], axi_wdata[m], wstrb[m], wlast[m], eid, a, esz, wd, estrb);
        end
      end
      step;
    end
    if (!w) model_rdata[m][p] = rd;
    clear_slave(m);
    @(negedge clk);
    checks++;
    if ({dok[m][1], dok[m][0], rdata[m][1], rdata[m][0]} !== {2'b00, model_rdata[m][1], model_rdata[m][0]}) begin
      errors++;
      $display("FAIL completion m%0d got ok %b%b rdata %h/%h exp ok 00 rdata %h/%h", m, dok[m][1], dok[m][0],
               rdata[m][1], rdata[m][0], model_rdata[m][1], model_rdata[m][0]);
    end
    step;
  endtask

  task automatic test_reset;
    for (int m = 0; m < 2; m++) rst[m] = 1'b1;
    step; step;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({arvalid[m], rready[m], awvalid[m], wvalid[m], bready[m], dok[m][1], dok[m][0],
           aok[m][1], aok[m][0], rdata[m][1], rdata[m][0]} !== {9'd0, 64'd0}) begin
        errors++;
        $display("FAIL reset_state m%0d got v %b%b%b%b%b ok %b%b rdata %h/%h exp all zero", m,
                 arvalid[m], rready[m], awvalid[m], wvalid[m], bready[m], dok[m][1], dok[m][0], rdata[m][1], rdata[m][0]);
      end
      checks++;
      if ({arlen[m], arburst[m], arlock[m], arcache[m], arprot[m], awlen[m], awburst[m], awlock[m],
           awcache[m], awprot[m], wlast[m]} !== {4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1}) begin
        errors++;
        $display("FAIL reset_consts m%0d got arlen %0d arburst %b awlen %0d awburst %b wlast %b exp 0 01 0 01 1",
                 m, arlen[m], arburst[m], awlen[m], awburst[m], wlast[m]);
      end
    end
    step;
    for (int m = 0; m < 2; m++) begin
      rst[m] = 1'b0;
      model_reset(m);
    end
  endtask

  task automatic test_directed;
    run_txn(0, 0, 1'b0, 2'd2, 32'hBFC00000, 32'h0, 32'h3C080001, 0, 0, 0, 0, 0);
    run_txn(0, 1, 1'b1, 2'd0, 32'h80000003, 32'h44444444, 32'h0, 0, 0, 0, 0, 5);
    run_txn(0, 1, 1'b1, 2'd1, 32'h80000002, 32'h55667788, 32'h0, 0, 0, 0, 3, 0);
    run_txn(1, 0, 1'b1, 2'd3, 32'h00001001, 32'hCAFEF00D, 32'h0, 2, 0, 1, 0, 1);
  endtask

  // Both ports request reads together, zero-wait slave.
  task automatic test_arb(input int m, input int reps);
    int win, lose;
    logic [31:0] d;
    do_reset(m);
    for (int r = 0; r < reps; r++) begin
      for (int p = 0; p < 2; p++) begin
        req[m][p] = 1'b1; wr[m][p] = 1'b0; size[m][p] = 2'd2; addr[m][p] = 32'h1000 * (p + 1) + 32'(r * 4);
      end
      win  = (m == 0) ? 1 : 1 - model_last[m];
      lose = 1 - win;
      @(negedge clk);
      checks++;
      if ({aok[m][1], aok[m][0]} !== 2'(1 << win)) begin
        errors++;
        $display("FAIL arb_first m%0d rep %0d got %b exp %b", m, r, {aok[m][1], aok[m][0]}, 2'(1 << win));
      end
      model_last[m] = win;
      for (int k = 0; k < 2; k++) begin
        int cur;
        cur = (k == 0) ? win : lose;
        step; req[m][cur] = 1'b0; arready[m] = 1'b1;
        @(negedge clk);
        checks++;
        if ({arvalid[m], arid[m], araddr[m]} !== {1'b1, 4'(cur), 32'h1000 * 32'(cur + 1) + 32'(r * 4)}) begin
          errors++;
          $display("FAIL arb_ar m%0d rep %0d got v %b id %h addr %h exp id %h", m, r, arvalid[m], arid[m], araddr[m], 4'(cur));
        end
        d = $urandom;
        step; arready[m] = 1'b0; rvalid[m] = 1'b1; rdata_in[m] = d;
        step; rvalid[m] = 1'b0;
        model_rdata[m][cur] = d;
        @(negedge clk);
        checks++;
        if ({dok[m][1], dok[m][0], aok[m][1], aok[m][0], rdata[m][cur]}
            !== {2'(1 << cur), (k == 0) ? 2'(1 << lose) : 2'b00, d}) begin
          errors++;
          $display("FAIL arb_done m%0d rep %0d k %0d got ok %b%b aok %b%b rdata %h exp ok %b rdata %h", m, r, k,
                   dok[m][1], dok[m][0], aok[m][1], aok[m][0], rdata[m][cur], 2'(1 << cur), d);
        end
        if (k == 0) model_last[m] = lose;
      end
      step;
    end
  endtask

  task automatic test_reset_mid;
    int m;
    m = 0;
    req[m][0] = 1'b1; wr[m][0] = 1'b0; size[m][0] = 2'd2; addr[m][0] = 32'h2000;
    step; req[m][0] = 1'b0; arready[m] = 1'b1;
    step; arready[m] = 1'b0;
    @(negedge clk);
    checks++;
    if (rready[m] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rdata m%0d rready got %b exp 1", m, rready[m]);
    end
    rst[m] = 1'b1;
    step; rst[m] = 1'b0;
    model_reset(m);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({arvalid[m], rready[m], awvalid[m], wvalid[m], bready[m], dok[m][1], dok[m][0]} !== 7'd0) begin
        errors++;
        $display("FAIL midrst_idle m%0d cyc %0d got %b%b%b%b%b ok %b%b exp 0", m, c,
                 arvalid[m], rready[m], awvalid[m], wvalid[m], bready[m], dok[m][1], dok[m][0]);
      end
      step;
    end
    run_txn(m, 0, 1'b0, 2'd2, 32'hBFC00004, 32'h0, 32'h24080002, 1, 2, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int m;
      m = n % 2;
      run_txn(m, int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      rst[m] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        req[m][p] = 1'b0; wr[m][p] = 1'b0; size[m][p] = 2'd0; addr[m][p] = 32'd0; wdata[m][p] = 32'd0;
      end
      clear_slave(m);
      model_reset(m);
    end
    #1;
    test_reset;
    test_directed;
    test_arb(0, 2);
    test_arb(1, 4);
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
